// File: rtl/sec_cnt_pkg.sv
// Shared state type and BCD constants for the sec_countdown timer.
package sec_cnt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int unsigned BCD_SAT_VAL  = 999;
   localparam logic [11:0] BCD_SAT_CODE = 12'h999;

endpackage

// File: rtl/sec_bin2bcd.sv
// Combinational binary to three-digit BCD converter (double-dabble).
// Inputs above 999 saturate to 12'h999.
module sec_bin2bcd
   import sec_cnt_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic [WIDTH-1:0] bin_i,
   output logic [11:0]      bcd_o
);

   // Ten bits covers every value up to the saturation point.
   localparam int IN_W = 10;

   logic [IN_W-1:0] bin_w;
   logic [11:0]     acc;

   // NOTE: every variable gets a value at the top of always_comb, so no latch can be inferred.
   always_comb begin
      bin_w = IN_W'(bin_i);
      acc   = '0;
      for (int i = IN_W - 1; i >= 0; i--) begin
         for (int d = 0; d < 3; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
               acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
         end
         acc = {acc[10:0], bin_w[i]};
      end
      bcd_o = (32'(bin_i) > BCD_SAT_VAL) ? BCD_SAT_CODE : acc;
   end

endmodule

// File: rtl/sec_countdown.sv
// Seconds countdown timer: IDLE/RUN/PAUSED/DONE control around a down-counter.
// Define SEC_COUNTDOWN_AUTORELOAD_EN to reload the last loaded value and keep running on expiry.
module sec_countdown
   import sec_cnt_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic             CLOCK_50,
   input  logic             reset_n,
   input  logic             tick,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   output logic             gen_en,
   output logic [WIDTH-1:0] remaining,
   output logic [11:0]      remaining_bcd,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             done_q, done_d;
   logic             gen_en_q;
   logic             busy_q;
   logic             run_req;
   logic             expire;

`ifdef SEC_COUNTDOWN_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   // Pause outranks start, so both together never (re)starts the count.
   assign run_req = start & ~pause;
   assign expire  = tick & (rem_q == ONE);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
`ifdef SEC_COUNTDOWN_AUTORELOAD_EN
      reload_d = reload_q;
      if (load && (state_q != ST_DONE)) begin
         reload_d = load_val;
      end
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (load) begin
               rem_d = load_val;
            end else if (run_req && (rem_q != '0)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (load) begin
               rem_d   = load_val;
               state_d = ST_IDLE;
            end else if (expire) begin
               // Expiry wins over a simultaneous pause: the count has reached zero.
               rem_d   = '0;
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               if (tick && (rem_q != '0)) begin
                  rem_d = rem_q - ONE;
               end
               if (pause) begin
                  state_d = ST_PAUSED;
               end
            end
         end
         ST_PAUSED: begin
            if (load) begin
               rem_d   = load_val;
               state_d = ST_IDLE;
            end else if (run_req) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
`ifdef SEC_COUNTDOWN_AUTORELOAD_EN
            if (reload_q != '0) begin
               rem_d   = reload_q;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; status flags are
   // derived from state_d so they are registered yet line up with state_q.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         rem_q    <= '0;
         done_q   <= 1'b0;
         gen_en_q <= 1'b0;
         busy_q   <= 1'b0;
`ifdef SEC_COUNTDOWN_AUTORELOAD_EN
         // NOTE: the reload register is reset too, so expiry after reset can never restart from junk.
         reload_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         done_q   <= done_d;
         gen_en_q <= (state_d == ST_RUN);
         busy_q   <= (state_d == ST_RUN) || (state_d == ST_PAUSED);
`ifdef SEC_COUNTDOWN_AUTORELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   sec_bin2bcd #(
      .WIDTH (WIDTH)
   ) u_bin2bcd (
      .bin_i (rem_q),
      .bcd_o (remaining_bcd)
   );

   assign remaining = rem_q;
   assign done      = done_q;
   assign gen_en    = gen_en_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sec_countdown.sv
// Self-checking bench for sec_countdown: directed vector table, hand sequences, random vs. model.
module tb_sec_countdown;

   localparam int W = 9;
`ifdef SEC_COUNTDOWN_AUTORELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          tick = 1'b0;
   logic          load = 1'b0;
   logic [W-1:0]  load_val = '0;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic          gen_en;
   logic [W-1:0]  remaining;
   logic [11:0]   remaining_bcd;
   logic          busy;
   logic          done;

   int checks   = 0;
   int failures = 0;

   sec_countdown #(.WIDTH(W)) dut (
      .CLOCK_50      (clk),
      .reset_n       (reset_n),
      .tick          (tick),
      .load          (load),
      .load_val      (load_val),
      .start         (start),
      .pause         (pause),
      .gen_en        (gen_en),
      .remaining     (remaining),
      .remaining_bcd (remaining_bcd),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      int s;
      s = (v > 999) ? 999 : v;
      return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
   endfunction

   // Behavioural model: seconds left plus what the timer is currently doing.
   int m_rem, m_last;
   bit m_run, m_pause, m_done;

   function automatic void model_reset();
      m_rem = 0; m_last = 0; m_run = 0; m_pause = 0; m_done = 0;
   endfunction

   function automatic void model_step(input bit ld, input int lv, input bit st, input bit pa, input bit tk);
      if (m_done) begin
         m_done = 0;
         if (AUTO && m_last != 0) begin
            m_rem = m_last;
            m_run = 1;
         end
      end else if (ld) begin
         m_rem = lv; m_last = lv; m_run = 0; m_pause = 0;
      end else if (m_run) begin
         if (tk && m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_run = 0;
               m_done = 1;
            end
         end
         if (m_run && pa) begin
            m_run = 0;
            m_pause = 1;
         end
      end else if (m_pause) begin
         if (st && !pa) begin
            m_pause = 0;
            m_run = 1;
         end
      end else if (st && !pa && m_rem != 0) begin
         m_run = 1;
      end
   endfunction

   task automatic drive_cycle(input bit ld, input int lv, input bit st, input bit pa, input bit tk);
      load = ld; load_val = W'(lv); start = st; pause = pa; tick = tk;
      @(posedge clk);
      #1;
      model_step(ld, lv, st, pa, tk);
   endtask

   task automatic compare_model(input string tag);
      check({tag, "_rem"}, 32'(remaining), 32'(m_rem));
      check({tag, "_flags"}, {29'd0, done, busy, gen_en}, {29'd0, m_done, (m_run | m_pause), m_run});
      check({tag, "_bcd"}, 32'(remaining_bcd), 32'(to_bcd(m_rem)));
   endtask

   typedef struct {
      bit ld; int lv; bit st; bit pa; bit tk;
      int rem; bit dn; bit bsy; bit gen;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input bit ld, input int lv, input bit st, input bit pa, input bit tk,
                               input int rem, input bit dn, input bit bsy, input bit gen);
      vec_t v;
      v.ld = ld; v.lv = lv; v.st = st; v.pa = pa; v.tk = tk;
      v.rem = rem; v.dn = dn; v.bsy = bsy; v.gen = gen;
      vecs.push_back(v);
   endfunction

   initial begin
      int dut_dones, mdl_dones;

      // load 0 / start ignored / tick at zero
      add(1, 0, 0, 0, 0,   0, 0, 0, 0);
      add(0, 0, 1, 0, 0,   0, 0, 0, 0);
      add(0, 0, 0, 0, 1,   0, 0, 0, 0);
      // 3-second run
      add(1, 3, 0, 0, 0,   3, 0, 0, 0);
      add(0, 0, 1, 0, 0,   3, 0, 1, 1);
      add(0, 0, 0, 0, 1,   2, 0, 1, 1);
      add(0, 0, 0, 0, 1,   1, 0, 1, 1);
      add(0, 0, 0, 0, 1,   0, 1, 0, 0);
      add(0, 0, 0, 0, 0,   AUTO ? 3 : 0, 0, AUTO, AUTO);
      // pause / resume
      add(1, 5, 0, 0, 0,   5, 0, 0, 0);
      add(0, 0, 1, 0, 0,   5, 0, 1, 1);
      add(0, 0, 0, 0, 1,   4, 0, 1, 1);
      add(0, 0, 0, 1, 0,   4, 0, 1, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1,   4, 0, 1, 0);
      add(0, 0, 1, 0, 0,   4, 0, 1, 1);
      add(0, 0, 0, 0, 1,   3, 0, 1, 1);
      add(0, 0, 0, 0, 1,   2, 0, 1, 1);
      add(0, 0, 0, 0, 1,   1, 0, 1, 1);
      add(0, 0, 0, 0, 1,   0, 1, 0, 0);
      add(0, 0, 0, 0, 0,   AUTO ? 5 : 0, 0, AUTO, AUTO);
      // load aborts a run, tick in the same cycle ignored
      add(1, 4, 0, 0, 0,   4, 0, 0, 0);
      add(0, 0, 1, 0, 0,   4, 0, 1, 1);
      add(0, 0, 0, 0, 1,   3, 0, 1, 1);
      add(0, 0, 0, 0, 1,   2, 0, 1, 1);
      add(1, 7, 0, 0, 1,   7, 0, 0, 0);
      add(0, 0, 0, 0, 0,   7, 0, 0, 0);
      // pause with tick, and input priority
      add(0, 0, 1, 0, 0,   7, 0, 1, 1);
      add(0, 0, 0, 1, 1,   6, 0, 1, 0);
      add(0, 0, 1, 1, 0,   6, 0, 1, 0);
      add(1, 9, 1, 1, 0,   9, 0, 0, 0);
      add(0, 0, 1, 1, 0,   9, 0, 0, 0);
      add(0, 0, 1, 0, 0,   9, 0, 1, 1);
      // BCD extremes
      add(1, 511, 0, 0, 0, 511, 0, 0, 0);
      add(1, 0, 0, 0, 0,   0, 0, 0, 0);
      add(0, 0, 1, 0, 0,   0, 0, 0, 0);

      // Reset state
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check("reset_rem", 32'(remaining), 32'd0);
      check("reset_flags", {29'd0, done, busy, gen_en}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;

      foreach (vecs[i]) begin
         drive_cycle(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].pa, vecs[i].tk);
         check($sformatf("tbl%0d_rem", i), 32'(remaining), 32'(vecs[i].rem));
         check($sformatf("tbl%0d_flags", i), {29'd0, done, busy, gen_en},
               {29'd0, vecs[i].dn, vecs[i].bsy, vecs[i].gen});
         check($sformatf("tbl%0d_bcd", i), 32'(remaining_bcd), 32'(to_bcd(vecs[i].rem)));
         compare_model($sformatf("tbl%0d_mdl", i));
      end

      // Reset in the middle of a run
      drive_cycle(1, 5, 0, 0, 0);
      drive_cycle(0, 0, 1, 0, 0);
      drive_cycle(0, 0, 0, 0, 1);
      check("midrun_rem_before", 32'(remaining), 32'd4);
      load = 0; start = 0; pause = 0; tick = 0;
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check("midrun_rem_async", 32'(remaining), 32'd0);
      check("midrun_flags_async", {29'd0, done, busy, gen_en}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      dut_dones = 0;
      for (int i = 0; i < 6; i++) begin
         drive_cycle(0, 0, 0, 0, 1);
         dut_dones += int'(done);
         compare_model($sformatf("postrst%0d", i));
      end
      check("postrst_no_done", 32'(dut_dones), 32'd0);

      // Short repeated run: one done per expiry, reloaded when enabled
      dut_dones = 0; mdl_dones = 0;
      drive_cycle(1, 2, 0, 0, 0);
      drive_cycle(0, 0, 1, 0, 0);
      for (int i = 0; i < 20; i++) begin
         drive_cycle(0, 0, 0, 0, bit'(i % 2));
         dut_dones += int'(done);
         mdl_dones += int'(m_done);
         compare_model($sformatf("auto%0d", i));
      end
      check("auto_done_count", 32'(dut_dones), 32'(mdl_dones));

      // Random stimulus against the model
      for (int i = 0; i < 600; i++) begin
         bit ld, st, pa, tk;
         int lv;
         ld = ($urandom_range(15) == 0);
         lv = ($urandom_range(7) == 0) ? int'($urandom_range(511)) : int'($urandom_range(6));
         st = ($urandom_range(3) == 0);
         pa = ($urandom_range(7) == 0);
         tk = bit'($urandom_range(1));
         drive_cycle(ld, lv, st, pa, tk);
         compare_model($sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sec_countdown.md
SEC_COUNTDOWN -- requirements
Module: sec_countdown

Interface
REQ-001 SHALL have parameter WIDTH, default 8, countdown register width in bits; legal range 1..9.
REQ-002 SHALL have port CLOCK_50, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tick, input, 1, one-cycle pulse per elapsed second from the one-second tick generator.
REQ-005 SHALL have port load, input, 1, capture load_val as the new countdown value.
REQ-006 SHALL have port load_val, input, WIDTH, start value in seconds.
REQ-007 SHALL have port start, input, 1, begin or resume counting.
REQ-008 SHALL have port pause, input, 1, suspend counting.
REQ-009 SHALL have port gen_en, output, 1, enable for the tick generator; high only in RUN.
REQ-010 SHALL have port remaining, output, WIDTH, seconds left.
REQ-011 SHALL have port remaining_bcd, output, 12, remaining as three BCD digits, hundreds in [11:8].
REQ-012 SHALL have port busy, output, 1, high in RUN or PAUSED.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when the count reaches zero.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSED, DONE.
REQ-015 IDLE: load writes load_val into remaining; start with remaining != 0 enters RUN next cycle; start with remaining == 0 is ignored.
REQ-016 RUN: each tick decrements remaining by 1; a tick at remaining == 1 sets remaining to 0, pulses done on the next cycle, and enters DONE.
REQ-017 RUN: pause enters PAUSED; a tick in the same cycle as pause is still applied.
REQ-018 PAUSED: ticks are ignored; start returns to RUN; load writes remaining and returns to IDLE.
REQ-019 RUN: load aborts the run, writes load_val, and returns to IDLE without done.
REQ-020 DONE: held one cycle, then returns to IDLE with remaining = 0.
REQ-021 Priority when several inputs are high in one cycle: load > pause > start.
REQ-022 remaining SHALL never wrap below 0; a tick at remaining == 0 has no effect.
REQ-023 remaining_bcd SHALL be combinational from remaining, zero latency; values above 999 saturate to 12'h999.
REQ-024 gen_en SHALL be registered and equal (state == RUN).

Reset
REQ-025 On reset_n low, outputs SHALL clear asynchronously: state = IDLE, remaining = 0, done = 0, gen_en = 0, busy = 0.
REQ-026 Reset mid-RUN SHALL abort with no done pulse; the first edge after deassertion is in IDLE.

Configuration
REQ-027 With SEC_COUNTDOWN_AUTORELOAD_EN defined, the block SHALL store the last loaded value; DONE SHALL reload it and re-enter RUN instead of IDLE, done still pulsing once per expiry.
REQ-028 Without SEC_COUNTDOWN_AUTORELOAD_EN, the block SHALL behave as REQ-020 and contain no reload register.

Structure
REQ-029 Package sec_cnt_pkg SHALL hold the state enum typedef and the BCD saturation constant 999.
REQ-030 Binary-to-BCD conversion SHALL be a sub-module, sec_bin2bcd (double-dabble, combinational).

Verification
REQ-031 load_val=3, load, start, 3 ticks -> remaining 3,2,1,0; done one cycle after the third tick; state IDLE; gen_en low.
REQ-032 load 5, start, 1 tick, pause, 4 ticks, start, 4 ticks -> remaining 4 held during pause; done after the final tick.
REQ-033 load 0, start -> remains IDLE, busy 0, gen_en 0, no done.
REQ-034 RUN at remaining 2, load_val=7 with load and tick in the same cycle -> remaining 7, IDLE, no done.
REQ-035 reset_n low mid-RUN at remaining 4 -> immediately remaining 0, gen_en 0; no done after release.
REQ-036 WIDTH=9, load 511 -> remaining_bcd 12'h511; load 0 -> 12'h000; with AUTORELOAD, load 2, run -> done every 2 ticks, continuously.
